// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-ported, 1-cycle-latency SRAM between instruction fetch and data access.
// Data wins conflicts; a streak limiter forces a fetch grant after MAX_DATA_STREAK data wins.
module sram_port_arbiter #(
    parameter int MAX_DATA_STREAK = 3,
    parameter int ADDR_W          = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,

    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    // A zero limit still needs a one-bit counter so the compare stays well formed.
    localparam int STREAK_W = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_owner_q, resp_owner_d;
    logic                streak_at_max;
    logic                grant_inst;
    logic                grant_data;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        streak_d      = streak_q;
        streak_at_max = (streak_q == STREAK_MAX);
        grant_data    = ~reset & data_req & ~(inst_req & streak_at_max);
        grant_inst    = ~reset & inst_req & ~grant_data;

        if (!inst_req || grant_inst) begin
            streak_d = '0;
        end else if (grant_data && !streak_at_max) begin
            streak_d = streak_q + STREAK_W'(1);
        end

        resp_valid_d = grant_inst | grant_data;
        resp_owner_d = grant_data;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= 1'b0;
        end else begin
            streak_q     <= streak_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    assign sram_en    = grant_inst | grant_data;
    assign sram_we    = grant_data & data_wr;
    assign sram_addr  = grant_inst ? inst_addr : (grant_data ? data_addr : '0);
    assign sram_wdata = grant_data ? data_wdata : '0;

    // Gating by reset drops a response whose grant happened just before reset rose.
    assign inst_data_ok = ~reset & resp_valid_q & ~resp_owner_q;
    assign data_data_ok = ~reset & resp_valid_q &  resp_owner_q;
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;

    inst_addr_held: assert property (@(posedge clk) disable iff (reset)
        (inst_req && !inst_addr_ok) |=> (!inst_req || $stable(inst_addr)));

    data_req_held: assert property (@(posedge clk) disable iff (reset)
        (data_req && !data_addr_ok) |=>
            (!data_req || ($stable(data_addr) && $stable(data_wr) && $stable(data_wdata))));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model with its own memory image.
module tb_sram_port_arbiter;

    localparam int MAX_STREAK = 3;
    localparam int AW         = 32;

    logic          clk;
    logic          reset;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [31:0]   inst_rdata;
    logic          data_req;
    logic          data_wr;
    logic [AW-1:0] data_addr;
    logic [31:0]   data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [31:0]   data_rdata;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    sram_port_arbiter #(.MAX_DATA_STREAK(MAX_STREAK), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // 1 KB memory image (word index = addr[9:2]); 0x1c000000 aliases to word 0.
    function automatic logic [31:0] init_word(input logic [7:0] idx);
        if (idx == 8'd0) return 32'h0280_0c0c;
        return ({24'h0, idx} * 32'h9E37_79B1) ^ 32'hA5A5_A5A5;
    endfunction

    logic [31:0] sram_mem     [256];
    bit          sram_written [256];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                sram_mem[sram_addr[9:2]]     <= sram_wdata;
                sram_written[sram_addr[9:2]] <= 1'b1;
            end else begin
                sram_rdata <= sram_written[sram_addr[9:2]] ? sram_mem[sram_addr[9:2]]
                                                           : init_word(sram_addr[9:2]);
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem     [256];
    bit          ref_written [256];
    int          m_streak;
    logic        m_resp_valid, m_resp_owner, m_resp_is_load;
    logic [31:0] m_resp_data;
    logic        last_gi, last_gd;

    // Snapshot of DUT outputs at the most recent sample point
    logic        obs_iao, obs_dao, obs_en, obs_we, obs_ido, obs_ddo;
    logic [31:0] obs_addr, obs_drdata, obs_irdata;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_written[a[9:2]] ? ref_mem[a[9:2]] : init_word(a[9:2]);
    endfunction

    // One clock: sample and compare at the falling edge, advance the model, return after posedge.
    task automatic run_cycle();
        logic        exp_gi, exp_gd, exp_ido, exp_ddo;
        logic [31:0] exp_addr, exp_wdata;
        @(negedge clk);
        if (reset) begin
            exp_gi = 1'b0; exp_gd = 1'b0;
        end else if (inst_req && data_req) begin
            exp_gd = (m_streak < MAX_STREAK);
            exp_gi = !exp_gd;
        end else begin
            exp_gi = inst_req; exp_gd = data_req;
        end
        exp_addr  = exp_gi ? inst_addr : (exp_gd ? data_addr : 32'h0);
        exp_wdata = exp_gd ? data_wdata : 32'h0;
        exp_ido   = !reset && m_resp_valid && !m_resp_owner;
        exp_ddo   = !reset && m_resp_valid && m_resp_owner;

        obs_iao = inst_addr_ok; obs_dao = data_addr_ok; obs_en = sram_en; obs_we = sram_we;
        obs_addr = sram_addr; obs_ido = inst_data_ok; obs_ddo = data_data_ok;
        obs_irdata = inst_rdata; obs_drdata = data_rdata;

        n_checks++;
        if ({obs_iao, obs_dao} !== {exp_gi, exp_gd})
            $display("FAIL grant t=%0t: inst/data addr_ok=%b%b expected %b%b",
                     $time, obs_iao, obs_dao, exp_gi, exp_gd);
        else n_pass++;
        n_checks++;
        if ({obs_en, obs_we} !== {exp_gi | exp_gd, exp_gd & data_wr})
            $display("FAIL sram_ctl t=%0t: en/we=%b%b expected %b%b",
                     $time, obs_en, obs_we, exp_gi | exp_gd, exp_gd & data_wr);
        else n_pass++;
        n_checks++;
        if (obs_addr !== exp_addr || sram_wdata !== exp_wdata)
            $display("FAIL sram_bus t=%0t: addr=%h wdata=%h expected addr=%h wdata=%h",
                     $time, obs_addr, sram_wdata, exp_addr, exp_wdata);
        else n_pass++;
        n_checks++;
        if ({obs_ido, obs_ddo} !== {exp_ido, exp_ddo})
            $display("FAIL data_ok t=%0t: inst/data data_ok=%b%b expected %b%b",
                     $time, obs_ido, obs_ddo, exp_ido, exp_ddo);
        else n_pass++;
        if (exp_ido && m_resp_is_load) begin
            n_checks++;
            if (obs_irdata !== m_resp_data)
                $display("FAIL inst_rdata t=%0t: got %h expected %h", $time, obs_irdata, m_resp_data);
            else n_pass++;
        end
        if (exp_ddo && m_resp_is_load) begin
            n_checks++;
            if (obs_drdata !== m_resp_data)
                $display("FAIL data_rdata t=%0t: got %h expected %h", $time, obs_drdata, m_resp_data);
            else n_pass++;
        end

        if (reset) begin
            m_resp_valid = 1'b0;
            m_resp_owner = 1'b0;
            m_streak     = 0;
        end else begin
            m_resp_valid   = exp_gi | exp_gd;
            m_resp_owner   = exp_gd;
            m_resp_is_load = exp_gi | (exp_gd & !data_wr);
            if (exp_gi) begin
                m_resp_data = ref_read(inst_addr);
            end else if (exp_gd && data_wr) begin
                ref_mem[data_addr[9:2]]     = data_wdata;
                ref_written[data_addr[9:2]] = 1'b1;
            end else if (exp_gd) begin
                m_resp_data = ref_read(data_addr);
            end
            if (!inst_req || exp_gi) m_streak = 0;
            else if (exp_gd)        m_streak++;
        end
        last_gi = exp_gi;
        last_gd = exp_gd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
        run_cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1; inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1;
        inst_addr = 32'h0000_0010; data_addr = 32'h0000_0020; data_wdata = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            n_checks++;
            if ({obs_iao, obs_dao, obs_en, obs_we, obs_ido, obs_ddo} !== 6'b0)
                $display("FAIL reset_outputs: iao,dao,en,we,ido,ddo=%b expected 000000",
                         {obs_iao, obs_dao, obs_en, obs_we, obs_ido, obs_ddo});
            else n_pass++;
        end
        reset = 1'b0;
        idle();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            idle();
            n_checks++;
            if ({obs_en, obs_ido, obs_ddo} !== 3'b0 || obs_addr !== 32'h0)
                $display("FAIL idle: en,ido,ddo=%b addr=%h expected 000 and 0",
                         {obs_en, obs_ido, obs_ddo}, obs_addr);
            else n_pass++;
        end
    endtask

    task automatic test_inst_only();
        inst_req = 1'b1; inst_addr = 32'h1c00_0000;
        run_cycle();
        n_checks++;
        if ({obs_iao, obs_en, obs_we} !== 3'b110)
            $display("FAIL inst_grant: addr_ok,en,we=%b expected 110", {obs_iao, obs_en, obs_we});
        else n_pass++;
        inst_req = 1'b0;
        run_cycle();
        n_checks++;
        if (obs_ido !== 1'b1 || obs_ddo !== 1'b0 || obs_irdata !== 32'h0280_0c0c)
            $display("FAIL inst_resp: ido=%b ddo=%b rdata=%h expected 1 0 02800c0c",
                     obs_ido, obs_ddo, obs_irdata);
        else n_pass++;
        idle();
    endtask

    task automatic test_back_to_back();
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h100; data_wdata = 32'hdead_beef;
        run_cycle();
        n_checks++;
        if ({obs_dao, obs_we} !== 2'b11)
            $display("FAIL store_grant: addr_ok,we=%b expected 11", {obs_dao, obs_we});
        else n_pass++;
        data_wr = 1'b0; data_wdata = 32'h0;
        run_cycle();
        n_checks++;
        if ({obs_dao, obs_we, obs_ddo} !== 3'b101)
            $display("FAIL load_grant: addr_ok,we,data_ok=%b expected 101", {obs_dao, obs_we, obs_ddo});
        else n_pass++;
        data_req = 1'b0;
        run_cycle();
        n_checks++;
        if (obs_ddo !== 1'b1 || obs_we !== 1'b0 || obs_drdata !== 32'hdead_beef)
            $display("FAIL load_resp: data_ok=%b we=%b rdata=%h expected 1 0 deadbeef",
                     obs_ddo, obs_we, obs_drdata);
        else n_pass++;
        idle();
    endtask

    task automatic test_conflict();
        logic [7:0] seq;
        int         one_hot_errs;
        one_hot_errs = 0;
        inst_req = 1'b1; inst_addr = 32'h1c00_0004;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0200;
        for (int i = 0; i < 8; i++) begin
            run_cycle();
            seq[i] = obs_dao;
            if ((obs_iao ^ obs_dao) !== 1'b1) one_hot_errs++;
        end
        n_checks++;
        if (seq !== 8'b0111_0111)
            $display("FAIL conflict_seq: data-grant bits (cycle0=lsb) %b expected 01110111", seq);
        else n_pass++;
        n_checks++;
        if (one_hot_errs != 0)
            $display("FAIL conflict_onehot: %0d cycles without exactly one addr_ok, expected 0",
                     one_hot_errs);
        else n_pass++;
        idle();
        idle();
    endtask

    task automatic test_streak_reset();
        logic [6:0] seq;
        logic [6:0] inst_pattern;
        inst_pattern = 7'b1111_011;  // inst_req per cycle, cycle0 = lsb
        inst_addr = 32'h1c00_0008;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0040;
        for (int i = 0; i < 7; i++) begin
            inst_req = inst_pattern[i];
            run_cycle();
            seq[i] = obs_dao;
        end
        n_checks++;
        if (seq !== 7'b011_1111)
            $display("FAIL streak_reset_seq: data-grant bits %b expected 0111111", seq);
        else n_pass++;
        idle();
        idle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            data_req = 1'b1; data_wr = i[0]; data_addr = 32'h0000_0300 + 32'(i * 4);
            data_wdata = 32'hc0de_0000 + 32'(i);
            run_cycle();
        end
        data_req = 1'b0; data_wr = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1c00_0000;
        run_cycle();
        n_checks++;
        if (obs_iao !== 1'b1)
            $display("FAIL reset_mid_grant: inst_addr_ok=%b expected 1", obs_iao);
        else n_pass++;
        reset = 1'b1; inst_req = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0; data_wdata = 32'hbad0_bad0;
        for (int i = 0; i < 2; i++) begin
            run_cycle();
            n_checks++;
            if ({obs_iao, obs_dao, obs_en, obs_we, obs_ido, obs_ddo} !== 6'b0)
                $display("FAIL reset_mid_outputs: iao,dao,en,we,ido,ddo=%b expected 000000",
                         {obs_iao, obs_dao, obs_en, obs_we, obs_ido, obs_ddo});
            else n_pass++;
        end
        reset = 1'b0; data_req = 1'b0; data_wr = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1c00_0000;
        run_cycle();
        n_checks++;
        if (obs_iao !== 1'b1 || obs_ido !== 1'b0)
            $display("FAIL reset_mid_restart: addr_ok=%b data_ok=%b expected 1 0", obs_iao, obs_ido);
        else n_pass++;
        inst_req = 1'b0;
        run_cycle();
        n_checks++;
        if (obs_ido !== 1'b1 || obs_irdata !== 32'h0280_0c0c)
            $display("FAIL reset_mid_resp: data_ok=%b rdata=%h expected 1 02800c0c", obs_ido, obs_irdata);
        else n_pass++;
        idle();
    endtask

    function automatic logic [31:0] rand_addr();
        return {4'($urandom_range(0, 3)), 18'h0, 8'($urandom_range(0, 31)), 2'b00};
    endfunction

    task automatic test_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            if (!inst_req || last_gi) begin
                inst_req  = ($urandom_range(0, 99) < 55);
                inst_addr = rand_addr();
            end
            if (!data_req || last_gd) begin
                data_req   = ($urandom_range(0, 99) < 65);
                data_wr    = ($urandom_range(0, 99) < 40);
                data_addr  = rand_addr();
                data_wdata = $urandom();
            end
            reset = ($urandom_range(0, 99) < 2);
            run_cycle();
        end
        reset = 1'b0;
        idle();
        idle();
    endtask

    initial begin
        reset = 1'b1; inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0;
        m_streak = 0; m_resp_valid = 1'b0; m_resp_owner = 1'b0;
        m_resp_is_load = 1'b0; m_resp_data = '0; last_gi = 1'b0; last_gd = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]     = '0;
            ref_written[i] = 1'b0;
        end

        test_reset();
        test_idle();
        test_inst_only();
        test_back_to_back();
        test_conflict();
        test_streak_reset();
        test_reset_mid();
        test_random(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
